serial_adder_8bit: RTL and testbench
====================================

// Module: serial_adder_8bit
// PURPOSE
//  Bit-serial unsigned adder. It computes s = a + b, with carry-out cout, LSB first,
//  one bit per clock, through a single full-adder cell and a carry flip-flop.
//  It is the additive counterpart of the ripple subtractor datapath.
//  It trades WIDTH cycles of latency for a single FA cell.
//  Operands are captured with a start/busy/done handshake.
// PARAMETERS
//  WIDTH  8  operand and sum width in bits; must be >= 2
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  addend A; captured on the accepted start edge
//  b      in   WIDTH  addend B; captured on the accepted start edge
//  s      out  WIDTH  sum; valid from done onward, held until the next accepted start
//  cout   out  1      carry out of the MSB; same validity as s
//  busy   out  1      high from the cycle after an accepted start through the done cycle
//  done   out  1      single-cycle pulse; s and cout are valid in this cycle
// BEHAVIOUR
//  Reset (async, any time): state=IDLE; s=0, cout=0, busy=0, done=0.
//   Internal operand and shift registers, carry FF and bit counter are all cleared.
//   An operation in flight is abandoned; no done pulse is produced.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - start=1 at edge E0: latch a and b into shift registers, carry=0, cnt=0, go to RUN.
//   - start=0: stay in IDLE; s and cout hold their last values.
//  RUN (edges E1..E_WIDTH):
//   - bit = aq[0] ^ bq[0] ^ c.
//   - c <= maj(aq[0], bq[0], c).
//   - Shift aq and bq right by 1.
//   - Shift bit in at the MSB of the sum shift register (after WIDTH shifts it is LSB-aligned).
//   - cnt increments each edge; on the edge where cnt==WIDTH-1, go to DONE.
//  DONE (one cycle):
//   - Transfer the sum register to s and the carry FF to cout.
//   - done=1, busy=1. The next edge returns to IDLE.
//  Latency: start sampled at E0 -> done high in the cycle after E_WIDTH.
//   That is WIDTH+1 clocks from start to done (9 for WIDTH=8).
//   Throughput is one operation per WIDTH+2 clocks.
//  start while busy (RUN or DONE): ignored. It is not queued, and a and b are not re-sampled.
//  a and b may change freely after the accepting edge; they do not affect the result.
//  Arithmetic: modulo 2^WIDTH; {cout, s} == a + b exactly (WIDTH+1-bit result).
//  s and cout update only in DONE and are stable at every other time, so they are glitch-free.
//  Operand changes during RUN have no effect.
// CONFIGURATION
//  Macro SERIAL_ADD_OVF_EN:
//   - Defined: adds port ovf (out, 1).
//     - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
//     - It is registered alongside s in DONE, reset to 0, and held like s.
//   - Undefined: the ovf port and its logic are absent. All other behaviour is identical.
// TESTING
//  1 Reset, then start with a=8'h35, b=8'h4A -> done 9 clocks later.
//     Response: s=8'h7F, cout=0, busy high for 9 cycles; ovf=0 if enabled.
//  2 a=8'hFF, b=8'h01 -> s=8'h00, cout=1; ovf=0 if enabled.
//     Then a=8'h00, b=8'h00 -> s=8'h00, cout=0.
//  3 a=8'h7F, b=8'h01 -> s=8'h80, cout=0, ovf=1.
//     Then a=8'h80, b=8'h80 -> s=8'h00, cout=1, ovf=1.
//  4 Start a=8'h10, b=8'h20. Pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 and again in the DONE cycle.
//     Response: a single done with s=8'h30; no second operation begins.
//  5 Start a=8'hAA, b=8'h55. Assert rst at RUN cycle 4.
//     Response: s, cout, busy and done are immediately 0; no done pulse follows.
//     A new start with a=8'h01, b=8'h02 then gives s=8'h03.
//  6 Randomised sweep of 1000 (a, b) pairs with back-to-back starts issued in the cycle after done.
//     Response: {cout, s} == a + b every time, and s is stable between done pulses.

Source files
------------

// File: rtl/serial_adder_8bit_if.sv
// Handshake and data bundle for the bit-serial adder.
// Carries ovf only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  s, cout, busy, done
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output s, cout, busy, done
    );
endinterface

// File: rtl/serial_adder_8bit.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first, WIDTH clocks per add.
// Optional signed-overflow output under macro SERIAL_ADD_OVF_EN.
module serial_adder_8bit #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_adder_8bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] aq;
    logic [WIDTH-1:0] bq;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             c;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    logic fa_sum;
    logic fa_cry;

    assign fa_sum = aq[0] ^ bq[0] ^ c;
    assign fa_cry = (aq[0] & bq[0]) | (aq[0] & c) | (bq[0] & c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            aq     <= '0;
            bq     <= '0;
            sr     <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        aq     <= bus.a;
                        bq     <= bus.b;
                        c      <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    aq  <= aq >> 1;
                    bq  <= bq >> 1;
                    c   <= fa_cry;
                    sr  <= {fa_sum, sr[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    // Last bit: publish so s/cout are valid in the DONE cycle
                    if (cnt == LAST) begin
                        s_q    <= {fa_sum, sr[WIDTH-1:1]};
                        cout_q <= fa_cry;
                        done_q <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q  <= c ^ fa_cry;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_8bit.sv
// Self-checking bench for serial_adder_8bit against an arithmetic reference.
// Covers directed cases, ignored starts, mid-run reset and a random sweep.
module tb_serial_adder_8bit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [8:0] prev;

    serial_adder_8bit_if #(.WIDTH(8)) bus ();

    serial_adder_8bit #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inj: poke start with FF/FF at RUN cycle 3 and in the DONE cycle
    task automatic op(input logic [7:0] av, input logic [7:0] bv,
                      input bit lat, input bit inj);
        logic [8:0] exp;
        int         k;
        int         nbusy;
        bit         held;
        int         extra;
        exp = {1'b0, av} + {1'b0, bv};
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        k     = 1;
        nbusy = 0;
        held  = 1'b1;
        while (!bus.done && k < 20) begin
            if (bus.busy) nbusy++;
            if ({bus.cout, bus.s} !== prev) held = 1'b0;
            if (inj && k == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        check("done_seen", {31'b0, bus.done}, 32'd1);
        if (bus.busy) nbusy++;
        check("sum", {23'b0, bus.cout, bus.s}, {23'b0, exp});
        check("hold", {31'b0, held}, 32'd1);
        if (lat) begin
            check("latency", k, 9);
            check("busy_cycles", nbusy, 9);
        end
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", {31'b0, bus.ovf},
              {31'b0, (av[7] == bv[7]) && (exp[7] != av[7])});
`endif
        prev = exp;
        if (inj) begin
            bus.start = 1'b1;
            bus.a     = 8'hFF;
            bus.b     = 8'hFF;
            @(negedge clk);
            bus.start = 1'b0;
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus.done || bus.busy) extra++;
                @(negedge clk);
            end
            check("no_second_op", extra, 0);
            check("sum_kept", {23'b0, bus.cout, bus.s}, {23'b0, exp});
        end
    endtask

    initial begin
        int extra;
        logic [7:0] ra;
        logic [7:0] rb;
        n_cmp     = 0;
        n_err     = 0;
        prev      = '0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_s", {24'b0, bus.s}, 32'd0);
        check("rst_cout", {31'b0, bus.cout}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        rst = 1'b0;

        op(8'h35, 8'h4A, 1'b1, 1'b0);
        op(8'hFF, 8'h01, 1'b1, 1'b0);
        op(8'h00, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b1, 1'b0);
        op(8'h80, 8'h80, 1'b1, 1'b0);
        op(8'h10, 8'h20, 1'b1, 1'b1);

        // Mid-run reset abandons the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_s", {24'b0, bus.s}, 32'd0);
        check("arst_cout", {31'b0, bus.cout}, 32'd0);
        check("arst_busy", {31'b0, bus.busy}, 32'd0);
        check("arst_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        prev = '0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) extra++;
            @(negedge clk);
        end
        check("no_done_after_rst", extra, 0);
        op(8'h01, 8'h02, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op(ra, rb, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
